mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between two requesters: the instruction-fetch path (read-only) and the load/store data path of the multicycle CPU.
- Sequences each access as a readM/writeM strobe held until the memory's inputReady/ackOutput handshake, then returns a one-cycle done pulse to the granted requester.
- Sits between the multicycle controller/datapath and the memory model.
- Provides a memory-access counter and a timeout error for debug.

Parameters:
- WORD_SIZE, 16, address/data width.
- TIMEOUT, 64, max cycles in READ/WRITE before abort (>=2).
- MAX_DATA_STREAK, 4, max consecutive data grants while a fetch is pending (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- Reset_N  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; hold with if_addr stable until if_done.
- if_addr  in  WORD_SIZE  fetch address.
- if_done  out  1  one-cycle pulse, fetch complete, rdata valid.
- d_req  in  1  data request; hold with d_we/d_addr/d_wdata stable until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_done  out  1  one-cycle pulse, data access complete (rdata valid if read).
- rdata  out  WORD_SIZE  last read word, held until the next read completes.
- mem_readM  out  1  memory read strobe.
- mem_writeM  out  1  memory write strobe.
- mem_address  out  WORD_SIZE  memory address.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_rdata  in  WORD_SIZE  memory read data, valid with mem_inputReady.
- mem_inputReady  in  1  read data valid.
- mem_ackOutput  in  1  write accepted.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on abort.
- num_mem_access  out  WORD_SIZE  count of completed accesses.

Behaviour:
- Reset (Reset_N=0 at posedge): state=IDLE, streak=0. All outputs 0, including rdata and num_mem_access. An in-flight access is dropped without a done pulse; strobes are low the cycle after the reset edge.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration, evaluated each cycle:
  - Data wins over fetch, except when if_req=1 and streak==MAX_DATA_STREAK; then fetch wins.
  - Granting fetch clears streak. Granting data while if_req=1 increments streak (saturating). Granting data with if_req=0 clears streak.
  - The winner's address (and wdata) is latched.
  - Next state: READ for a fetch or a data read; WRITE for a data write.
  - With no request, IDLE holds.
- READ: mem_readM=1, mem_address=latched address.
  - On mem_inputReady=1: rdata<=mem_rdata, go to DONE.
  - mem_ackOutput is ignored in READ.
- WRITE: mem_writeM=1, mem_address/mem_wdata=latched values.
  - On mem_ackOutput=1: go to DONE.
  - mem_inputReady is ignored in WRITE.
- DONE (one cycle):
  - Strobes low; the granted requester's done=1; num_mem_access+=1 (wraps at 2^WORD_SIZE).
  - Next state IDLE.
  - Requesters must drop req in the DONE cycle. A req still high in IDLE starts a new access.
- Latency: request seen in IDLE at edge t → strobe high after t. A handshake sampled at edge t+k → done high after t+k. Minimum 3 cycles request-to-done; back-to-back accesses every 3 cycles.
- Timeout: a cycle counter clears on entering READ/WRITE. If it reaches TIMEOUT without a handshake: strobes drop, timeout_err pulses, no done pulse, no counter increment, return to IDLE.
- A requester dropping req mid-access does not cancel it; done still pulses.
- Simultaneous if_req and d_req: resolved per the priority/streak rule only; the loser waits in IDLE.
- Strobes are never both high; at most one done pulses per cycle.

Decomposition:
- Shared package holds the state encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3) and the grant-select encoding (GNT_IF, GNT_D).
- Natural sub-module: mem_grant_select. It is combinational priority plus the registered streak counter, with inputs if_req/d_req/idle and outputs grant/valid.

Test Plan:
- Fetch only: if_addr=16'h0010; memory returns 16'hA5A5 with inputReady 2 cycles after readM → mem_address=0010, if_done 1 cycle, rdata=A5A5, num_mem_access=1.
- Data write: d_we=1, d_addr=16'h0200, d_wdata=16'h1234; ackOutput after 1 cycle → mem_writeM with those values, d_done pulse, mem_readM never high, rdata unchanged.
- Contention: if_req and d_req held continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,IF, repeating; no strobe overlap.
- Timeout: TIMEOUT=8, memory never responds to a read → readM high exactly 8 cycles, timeout_err pulse, no done, count unchanged, IDLE.
- Reset mid-READ: Reset_N=0 while readM=1 → next cycle all outputs 0, no done. After release, a new d_req read of 16'h0300 completes normally.
- Back-to-back: 3 fetches with immediate inputReady → if_done every 3 cycles, num_mem_access=3.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant selection.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_sel_e;

endpackage

// File: rtl/mem_grant_select.sv
// Fetch/data priority select with a data-streak limit so a pending fetch cannot starve.
module mem_grant_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic     clk,
  input  logic     Reset_N,
  input  logic     if_req,
  input  logic     d_req,
  input  logic     idle,
  output gnt_sel_e grant,
  output logic     valid
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    valid = idle && (if_req || d_req);
    grant = (d_req && !(if_req && (streak == STREAK_MAX))) ? GNT_D : GNT_IF;
  end

  // Streak only counts data grants that actually made a fetch wait.
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      streak <= '0;
    end else if (valid) begin
      if ((grant == GNT_IF) || !if_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; all outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE       = 16,
  parameter int TIMEOUT         = 64,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 Reset_N,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_inputReady,
  input  logic                 mem_ackOutput,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [WORD_SIZE-1:0] num_mem_access
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  arb_state_e    state, state_n;
  gnt_sel_e      grant, gnt_q;
  logic          grant_vld;
  logic          handshake;
  logic          abort;
  logic [TW-1:0] tcnt;

  mem_grant_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant_select (
    .clk    (clk),
    .Reset_N(Reset_N),
    .if_req (if_req),
    .d_req  (d_req),
    .idle   (state == IDLE),
    .grant  (grant),
    .valid  (grant_vld)
  );

  // A handshake on the last allowed cycle still wins over the abort.
  always_comb begin
    state_n   = state;
    handshake = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) state_n = ((grant == GNT_D) && d_we) ? WRITE : READ;
      end
      READ: begin
        if (mem_inputReady) begin
          state_n   = DONE;
          handshake = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ackOutput) begin
          state_n   = DONE;
          handshake = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      state          <= IDLE;
      gnt_q          <= GNT_IF;
      tcnt           <= '0;
      mem_readM      <= 1'b0;
      mem_writeM     <= 1'b0;
      busy           <= 1'b0;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      timeout_err    <= 1'b0;
      num_mem_access <= '0;
      rdata          <= '0;
      mem_address    <= '0;
      mem_wdata      <= '0;
    end else begin
      state       <= state_n;
      tcnt        <= ((state == READ) || (state == WRITE)) ? tcnt + 1'b1 : '0;
      mem_readM   <= (state_n == READ);
      mem_writeM  <= (state_n == WRITE);
      busy        <= (state_n != IDLE);
      if_done     <= handshake && (gnt_q == GNT_IF);
      d_done      <= handshake && (gnt_q == GNT_D);
      timeout_err <= abort;
      if (handshake) num_mem_access <= num_mem_access + 1'b1;
      if ((state == READ) && mem_inputReady) rdata <= mem_rdata;
      // mem_address/mem_wdata double as the latched request for the whole access.
      if ((state == IDLE) && grant_vld) begin
        gnt_q       <= grant;
        mem_address <= (grant == GNT_D) ? d_addr : if_addr;
        if ((grant == GNT_D) && d_we) mem_wdata <= d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int W     = 16;
  localparam int TO    = 8;
  localparam int MAXST = 4;

  logic         clk = 1'b0;
  logic         Reset_N;
  logic         if_req, d_req, d_we;
  logic [W-1:0] if_addr, d_addr, d_wdata;
  logic         if_done, d_done;
  logic [W-1:0] rdata, mem_address, mem_wdata, mem_rdata, num_mem_access;
  logic         mem_readM, mem_writeM, mem_inputReady, mem_ackOutput;
  logic         busy, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Transaction-level reference state
  int           streak;
  int           exp_count;
  logic [W-1:0] exp_rdata;
  int           done_cyc;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO), .MAX_DATA_STREAK(MAXST)) dut (
    .clk(clk), .Reset_N(Reset_N),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_inputReady(mem_inputReady), .mem_ackOutput(mem_ackOutput),
    .busy(busy), .timeout_err(timeout_err), .num_mem_access(num_mem_access)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " readM"}, mem_readM, 0);
    chk({tag, " writeM"}, mem_writeM, 0);
    chk({tag, " if_done"}, if_done, 0);
    chk({tag, " d_done"}, d_done, 0);
    chk({tag, " rdata"}, rdata, 0);
    chk({tag, " address"}, mem_address, 0);
    chk({tag, " wdata"}, mem_wdata, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " timeout"}, timeout_err, 0);
    chk({tag, " count"}, num_mem_access, 0);
  endtask

  // Precondition: called #1 into a cycle where the DUT is idle and at least one req is driven.
  // Returns in the next idle cycle. delay >= TO means the memory never answers.
  task automatic access(input int delay, input bit drop_mid, input logic [W-1:0] rd_val,
                        output bit obs_d);
    bit           win_d, is_wr;
    logic [W-1:0] a, wd;
    win_d = d_req && !(if_req && (streak == MAXST));
    if (!win_d) streak = 0;
    else if (if_req) streak = (streak < MAXST) ? streak + 1 : MAXST;
    else streak = 0;
    is_wr = win_d && d_we;
    a     = win_d ? d_addr : if_addr;
    wd    = d_wdata;
    @(posedge clk); #1;
    obs_d = (mem_address == d_addr) && (d_addr != if_addr) && d_req;
    chk("grant readM", mem_readM, !is_wr);
    chk("grant writeM", mem_writeM, is_wr);
    chk("grant address", mem_address, a);
    if (is_wr) chk("grant wdata", mem_wdata, wd);
    chk("grant busy", busy, 1);
    for (int j = 0; j < TO; j++) begin
      if (j > 0) begin
        chk("hold readM", mem_readM, !is_wr);
        chk("hold writeM", mem_writeM, is_wr);
        chk("hold no done", {if_done, d_done, timeout_err}, 0);
      end
      if (j == delay) begin
        if (is_wr) mem_ackOutput = 1'b1;
        else begin
          mem_inputReady = 1'b1;
          mem_rdata      = rd_val;
        end
      end else begin
        mem_rdata = W'($urandom);
        if (is_wr) mem_inputReady = 1'($urandom);
        else mem_ackOutput = 1'($urandom);
      end
      if (drop_mid && j == 0) begin
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      @(posedge clk); #1;
      mem_inputReady = 1'b0;
      mem_ackOutput  = 1'b0;
      if (j == delay) begin
        exp_count++;
        if (!is_wr) exp_rdata = rd_val;
        done_cyc = cyc;
        chk("done if_done", if_done, !win_d);
        chk("done d_done", d_done, win_d);
        chk("done strobes", {mem_readM, mem_writeM}, 0);
        chk("done rdata", rdata, exp_rdata);
        chk("done timeout", timeout_err, 0);
        chk("done busy", busy, 1);
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
        @(posedge clk); #1;
        chk("after done pulses", {if_done, d_done}, 0);
        chk("after done count", num_mem_access, 32'(exp_count & 16'hFFFF));
        chk("after done busy", busy, 0);
        break;
      end
      if (j == TO - 1) begin
        chk("abort timeout_err", timeout_err, 1);
        chk("abort no done", {if_done, d_done}, 0);
        chk("abort strobes", {mem_readM, mem_writeM}, 0);
        chk("abort busy", busy, 0);
        chk("abort count", num_mem_access, 32'(exp_count & 16'hFFFF));
        chk("abort rdata", rdata, exp_rdata);
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
    end
  endtask

  initial begin
    bit obs;
    int prev;
    Reset_N = 1'b0;
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_inputReady = 0; mem_ackOutput = 0;
    streak = 0; exp_count = 0; exp_rdata = '0; done_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    Reset_N = 1'b1;

    // Fetch only, memory answers two cycles after readM
    if_req = 1; if_addr = 16'h0010;
    access(2, 0, 16'hA5A5, obs);
    chk("fetch rdata", rdata, 16'hA5A5);
    chk("fetch count", num_mem_access, 1);

    // Data write, ack after one cycle
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    access(1, 0, 16'hFFFF, obs);
    chk("write rdata kept", rdata, 16'hA5A5);
    chk("write count", num_mem_access, 2);

    // Contention: both held, expect D,D,D,D,IF repeating
    if_req = 1; if_addr = 16'h0040;
    d_req = 1; d_we = 0; d_addr = 16'h0800;
    for (int i = 0; i < 10; i++) begin
      access(0, 0, W'($urandom), obs);
      chk("contention order", obs, (i % 5) != 4);
      if_req = 1; d_req = 1;
    end
    if_req = 0; d_req = 0;

    // Back-to-back fetches with immediate inputReady
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = W'(16'h0100 + i);
      access(0, 0, W'(16'hB000 + i), obs);
      if (i > 0) chk("b2b spacing", done_cyc - prev, 3);
      prev = done_cyc;
    end
    chk("b2b count", num_mem_access, 15);

    // Timeout on a fetch read the memory never answers
    if_req = 1; if_addr = 16'h0777;
    access(TO, 0, 16'h0, obs);
    @(posedge clk); #1;
    chk("timeout pulse width", timeout_err, 0);
    chk("timeout idle", busy, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (!if_req && !d_req && r == 0) begin
        @(posedge clk); #1;
        chk("idle hold busy", busy, 0);
        chk("idle hold strobes", {mem_readM, mem_writeM}, 0);
        continue;
      end
      if (!if_req && ($urandom_range(0, 1) == 1 || !d_req)) begin
        if_req = 1; if_addr = W'($urandom);
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_we = 1'($urandom); d_addr = W'($urandom); d_wdata = W'($urandom);
      end
      r = int'($urandom_range(0, 9));
      access((r < 8) ? int'($urandom_range(0, 3)) : TO, ($urandom_range(0, 4) == 0),
             W'($urandom), obs);
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;

    // Reset in the middle of a read
    if_req = 1; if_addr = 16'h0444;
    @(posedge clk); #1;
    chk("pre-reset readM", mem_readM, 1);
    Reset_N = 1'b0;
    @(posedge clk); #1;
    chk_zero("mid reset");
    if_req = 0;
    Reset_N = 1'b1;
    streak = 0; exp_count = 0; exp_rdata = '0;
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    access(1, 0, 16'h5A5A, obs);
    chk("post-reset rdata", rdata, 16'h5A5A);
    chk("post-reset count", num_mem_access, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
